// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one physical-memory line port
//               between the instruction cache and the data cache.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              I_pmem_read,
    input  logic [ADDR_W-1:0] I_pmem_address,
    output logic              I_pmem_resp,
    output logic [LINE_W-1:0] I_pmem_rdata,
    input  logic              D_pmem_read,
    input  logic              D_pmem_write,
    input  logic [ADDR_W-1:0] D_pmem_address,
    input  logic [LINE_W-1:0] D_pmem_wdata,
    output logic              D_pmem_resp,
    output logic [LINE_W-1:0] D_pmem_rdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;

    logic d_req;
    logic grant_d;

    assign d_req   = D_pmem_read | D_pmem_write;
    // On a tie the cache that was not served last wins.
    assign grant_d = d_req & ~(I_pmem_read & last_d_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        I_pmem_resp = 1'b0;
        D_pmem_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (I_pmem_read || d_req) begin
                    last_d_d = grant_d;
                    if (grant_d) begin
                        state_d = SERVE_D;
                        addr_d  = D_pmem_address;
                        wr_d    = D_pmem_write;
                        rd_d    = ~D_pmem_write;
                        if (D_pmem_write) begin
                            wdata_d = D_pmem_wdata;
                        end
                    end else begin
                        state_d = SERVE_I;
                        addr_d  = I_pmem_address;
                        rd_d    = 1'b1;
                        wr_d    = 1'b0;
                    end
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    I_pmem_resp = 1'b1;
                    state_d     = RECOVER;
                    rd_d        = 1'b0;
                    wr_d        = 1'b0;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    D_pmem_resp = 1'b1;
                    state_d     = RECOVER;
                    rd_d        = 1'b0;
                    wr_d        = 1'b0;
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign I_pmem_rdata = pmem_rdata;
    assign D_pmem_rdata = pmem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a
//               transaction-level reference model and a memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk            = 1'b0;
    logic          reset_n        = 1'b0;
    logic          I_pmem_read    = 1'b0;
    logic [AW-1:0] I_pmem_address = '0;
    logic          I_pmem_resp;
    logic [LW-1:0] I_pmem_rdata;
    logic          D_pmem_read    = 1'b0;
    logic          D_pmem_write   = 1'b0;
    logic [AW-1:0] D_pmem_address = '0;
    logic [LW-1:0] D_pmem_wdata   = '0;
    logic          D_pmem_resp;
    logic [LW-1:0] D_pmem_rdata;
    logic          pmem_resp      = 1'b0;
    logic [LW-1:0] pmem_rdata     = '0;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .I_pmem_read    (I_pmem_read),
        .I_pmem_address (I_pmem_address),
        .I_pmem_resp    (I_pmem_resp),
        .I_pmem_rdata   (I_pmem_rdata),
        .D_pmem_read    (D_pmem_read),
        .D_pmem_write   (D_pmem_write),
        .D_pmem_address (D_pmem_address),
        .D_pmem_wdata   (D_pmem_wdata),
        .D_pmem_resp    (D_pmem_resp),
        .D_pmem_rdata   (D_pmem_rdata),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: answers on the mem_lat-th cycle of a held strobe.
    int            mem_lat  = 5;
    bit            mem_auto = 1'b1;
    logic [LW-1:0] mem_line = {16{8'hA5}};

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_auto) begin
                pmem_rdata = mem_line;
                if ((pmem_read || pmem_write) && reset_n) begin
                    cnt++;
                    if (cnt >= mem_lat) begin
                        pmem_resp = 1'b1;
                        cnt       = 0;
                    end else begin
                        pmem_resp = 1'b0;
                    end
                end else begin
                    cnt       = 0;
                    pmem_resp = 1'b0;
                end
            end
        end
    end

    // Reference model: one in-flight transaction record plus a cooldown flag.
    logic          m_busy   = 1'b0;
    logic          m_cool   = 1'b0;
    logic          m_who_d  = 1'b0;
    logic          m_last_d = 1'b0;
    logic          m_wr     = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [LW-1:0] m_wdata  = '0;
    wire           m_any    = I_pmem_read | D_pmem_read | D_pmem_write;
    wire           m_pick_d = (D_pmem_read | D_pmem_write) & ~(I_pmem_read & m_last_d);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy   <= 1'b0;
            m_cool   <= 1'b0;
            m_who_d  <= 1'b0;
            m_last_d <= 1'b0;
            m_wr     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
        end else if (m_cool) begin
            m_cool <= 1'b0;
        end else if (m_busy) begin
            if (pmem_resp) begin
                m_busy <= 1'b0;
                m_cool <= 1'b1;
            end
        end else if (m_any) begin
            m_busy   <= 1'b1;
            m_who_d  <= m_pick_d;
            m_last_d <= m_pick_d;
            m_addr   <= m_pick_d ? D_pmem_address : I_pmem_address;
            m_wr     <= m_pick_d & D_pmem_write;
            if (m_pick_d && D_pmem_write) m_wdata <= D_pmem_wdata;
        end
    end

    logic          prev_strobe = 1'b0;
    logic [AW:0]   g_log[$];
    int            n_rd = 0, n_ir = 0, n_dr = 0;

    always @(negedge clk) begin
        chk("pmem_read",    pmem_read,    m_busy & ~m_wr);
        chk("pmem_write",   pmem_write,   m_busy & m_wr);
        chk("pmem_address", pmem_address, m_addr);
        chk("pmem_wdata",   pmem_wdata,   m_wdata);
        chk("I_pmem_resp",  I_pmem_resp,  m_busy & ~m_who_d & pmem_resp);
        chk("D_pmem_resp",  D_pmem_resp,  m_busy & m_who_d & pmem_resp);
        chk("I_pmem_rdata", I_pmem_rdata, pmem_rdata);
        chk("D_pmem_rdata", D_pmem_rdata, pmem_rdata);
        if (pmem_read)   n_rd++;
        if (I_pmem_resp) n_ir++;
        if (D_pmem_resp) n_dr++;
        if ((pmem_read || pmem_write) && !prev_strobe) g_log.push_back({pmem_write, pmem_address});
        prev_strobe = pmem_read | pmem_write;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_resp(input bit is_d, input string name);
        int k;
        for (k = 0; k < 100; k++) begin
            cyc();
            if (is_d ? D_pmem_resp : I_pmem_resp) break;
        end
        chk({name, "_resp_seen"}, k < 100, 1'b1);
    endtask

    int b_rd, b_ir, b_dr, b_log, nresp;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_read",  pmem_read,    1'b0);
        chk("rst_write", pmem_write,   1'b0);
        chk("rst_addr",  pmem_address, '0);
        chk("rst_wdata", pmem_wdata,   '0);
        reset_n = 1'b1;
        cyc();

        // Lone I read.
        b_rd = n_rd; b_ir = n_ir; b_dr = n_dr; b_log = g_log.size();
        mem_lat = 5;
        I_pmem_address = 16'h1230;
        I_pmem_read    = 1'b1;
        wait_resp(1'b0, "t1");
        chk("t1_rdata", I_pmem_rdata, {16{8'hA5}});
        I_pmem_read = 1'b0;
        repeat (3) cyc();
        chk("t1_read_cycles", n_rd - b_rd, 5);
        chk("t1_iresp_count", n_ir - b_ir, 1);
        chk("t1_dresp_count", n_dr - b_dr, 0);
        chk("t1_grant", g_log[b_log], {1'b0, 16'h1230});

        // Simultaneous I read and D write, twice.
        b_log = g_log.size();
        mem_lat = 3;
        I_pmem_address = 16'h0040; I_pmem_read  = 1'b1;
        D_pmem_address = 16'h8000; D_pmem_write = 1'b1;
        D_pmem_wdata   = {8{16'h1111}};
        wait_resp(1'b1, "t2a_d");
        chk("t2_wdata", pmem_wdata, {8{16'h1111}});
        D_pmem_write = 1'b0;
        wait_resp(1'b0, "t2a_i");
        I_pmem_read = 1'b0;
        cyc();
        I_pmem_address = 16'h0044; I_pmem_read  = 1'b1;
        D_pmem_address = 16'h8010; D_pmem_write = 1'b1;
        wait_resp(1'b1, "t2b_d");
        D_pmem_write = 1'b0;
        wait_resp(1'b0, "t2b_i");
        I_pmem_read = 1'b0;
        repeat (3) cyc();
        chk("t2_grant0", g_log[b_log],     {1'b1, 16'h8000});
        chk("t2_grant1", g_log[b_log + 1], {1'b0, 16'h0040});
        chk("t2_grant2", g_log[b_log + 2], {1'b1, 16'h8010});
        chk("t2_grant3", g_log[b_log + 3], {1'b0, 16'h0044});

        // Alternating fairness with both requests held.
        b_log = g_log.size();
        mem_lat = 2;
        nresp   = 0;
        I_pmem_address = 16'h0100; I_pmem_read = 1'b1;
        D_pmem_address = 16'h0200; D_pmem_read = 1'b1;
        for (int k = 0; k < 200 && nresp < 4; k++) begin
            cyc();
            if (I_pmem_resp || D_pmem_resp) nresp++;
        end
        I_pmem_read = 1'b0; D_pmem_read = 1'b0;
        repeat (3) cyc();
        chk("t3_resp_count", nresp, 4);
        chk("t3_grant0", g_log[b_log],     {1'b0, 16'h0200});
        chk("t3_grant1", g_log[b_log + 1], {1'b0, 16'h0100});
        chk("t3_grant2", g_log[b_log + 2], {1'b0, 16'h0200});
        chk("t3_grant3", g_log[b_log + 3], {1'b0, 16'h0100});
        chk("t3_count",  g_log.size() - b_log, 4);

        // Address stability while serving D.
        mem_lat = 6;
        D_pmem_address = 16'h2000; D_pmem_read = 1'b1;
        repeat (3) cyc();
        D_pmem_address = 16'h3000;
        cyc();
        chk("t4_addr_mid", pmem_address, 16'h2000);
        wait_resp(1'b1, "t4");
        chk("t4_addr_resp", pmem_address, 16'h2000);
        D_pmem_read = 1'b0;
        repeat (3) cyc();

        // Reset two cycles into SERVE_I.
        mem_lat = 20;
        I_pmem_address = 16'h7700; I_pmem_read = 1'b1;
        cyc();
        cyc();
        chk("t5_pre_read", pmem_read, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_read",  pmem_read,    1'b0);
        chk("t5_rst_iresp", I_pmem_resp,  1'b0);
        chk("t5_rst_dresp", D_pmem_resp,  1'b0);
        chk("t5_rst_addr",  pmem_address, '0);
        I_pmem_read    = 1'b0;
        D_pmem_address = 16'h5550; D_pmem_read = 1'b1;
        mem_lat = 3;
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("t5_d_read", pmem_read,    1'b1);
        chk("t5_d_addr", pmem_address, 16'h5550);
        wait_resp(1'b1, "t5");
        D_pmem_read = 1'b0;
        repeat (3) cyc();

        // Spurious pmem_resp while idle.
        mem_auto = 1'b0;
        cyc();
        pmem_resp = 1'b1;
        #1;
        chk("t6_iresp", I_pmem_resp, 1'b0);
        chk("t6_dresp", D_pmem_resp, 1'b0);
        cyc();
        pmem_resp = 1'b0;
        cyc();
        chk("t6_idle_read",  pmem_read,  1'b0);
        chk("t6_idle_write", pmem_write, 1'b0);
        I_pmem_address = 16'h0ABC; I_pmem_read = 1'b1;
        cyc();
        chk("t6_grant_read", pmem_read,    1'b1);
        chk("t6_grant_addr", pmem_address, 16'h0ABC);
        mem_auto = 1'b1;
        wait_resp(1'b0, "t6");
        I_pmem_read = 1'b0;
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
